// File: rtl/rw_burst_sequencer_if.sv
// Command/memory/transmit bundle for rw_burst_sequencer.
// slave : sequencer side (takes commands and TxDone, drives strobes and status).
// master: command decoder / memory / transmitter side.
interface rw_burst_sequencer_if #(
  parameter int ADDR_W  = 8,
  parameter int BURST_W = 2
);
  logic               Active;
  logic               CmdValid;
  logic               CmdReady;
  logic               CmdMode;
  logic               CmdRW;
  logic [ADDR_W-1:0]  CmdAddr;
  logic [BURST_W-1:0] CmdLen;
  logic               TxDone;
  logic               AccessMem;
  logic               RWMem;
  logic [ADDR_W-1:0]  MemAddr;
  logic               SampleData;
  logic               TxData;
  logic               Busy;
  logic               Done;
  logic               Error;

  modport slave (
    input  Active, CmdValid, CmdMode, CmdRW, CmdAddr, CmdLen, TxDone,
    output CmdReady, AccessMem, RWMem, MemAddr, SampleData, TxData, Busy, Done, Error
  );

  modport master (
    output Active, CmdValid, CmdMode, CmdRW, CmdAddr, CmdLen, TxDone,
    input  CmdReady, AccessMem, RWMem, MemAddr, SampleData, TxData, Busy, Done, Error
  );
endinterface

// File: rtl/rw_burst_sequencer.sv
// Burst memory / sample-transmit flow controller between command decoder and memory/serial TX.
// Latency: strobes and Busy appear one cycle after accept; Done pulses in the first IDLE cycle.
// Backpressure: CmdReady = Active && IDLE (combinational); TX beats stall until TxDone.
// Ports: Clk, Reset (async, active-high) plus bus (slave modport): command handshake
//   (CmdValid/CmdReady/CmdMode/CmdRW/CmdAddr/CmdLen), Active enable, TxDone, and registered
//   outputs AccessMem, RWMem, MemAddr, SampleData, TxData, Busy, Done, Error.
// Optional: define RWBS_TX_TIMEOUT_EN to abort a TX beat after TX_TIMEOUT cycles without TxDone
//   and raise the sticky Error flag; otherwise TX waits indefinitely and Error stays 0.
module rw_burst_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int BURST_W    = 2,
  parameter int MEM_LAT    = 2,
  parameter int TX_TIMEOUT = 16
) (
  input  logic                   Clk,
  input  logic                   Reset,
  rw_burst_sequencer_if.slave    bus
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int TXC_W = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);
  localparam logic [TXC_W-1:0] TX_LAST  = TXC_W'(TX_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_SAMPLE, S_TX} state_t;

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic               rw_q, rw_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BURST_W-1:0] beats_q, beats_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [TXC_W-1:0]   tx_cnt_q, tx_cnt_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               access_q, access_d;
  logic               rwmem_q, rwmem_d;
  logic               sample_q, sample_d;
  logic               tx_q, tx_d;
  logic               busy_q, busy_d;
  logic               beat_end;

  assign bus.CmdReady   = bus.Active && (state_q == S_IDLE);
  assign bus.AccessMem  = access_q;
  assign bus.RWMem      = rwmem_q;
  assign bus.MemAddr    = addr_q;
  assign bus.SampleData = sample_q;
  assign bus.TxData     = tx_q;
  assign bus.Busy       = busy_q;
  assign bus.Done       = done_q;
  assign bus.Error      = err_q;

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    beats_d  = beats_q;
    lat_d    = lat_q;
    tx_cnt_d = tx_cnt_q;
    err_d    = err_q;
    done_d   = 1'b0;
    beat_end = 1'b0;

    if (!bus.Active) begin
      // Abort: partial burst and address are discarded, Error is left as is.
      state_d  = S_IDLE;
      addr_d   = '0;
      beats_d  = '0;
      lat_d    = '0;
      tx_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.CmdValid) begin
            mode_d   = bus.CmdMode;
            rw_d     = bus.CmdRW;
            beats_d  = bus.CmdLen;
            lat_d    = '0;
            tx_cnt_d = '0;
            err_d    = 1'b0;
            if (bus.CmdMode) begin
              // Sample flow never touches memory, so MemAddr keeps its last value there.
              addr_d  = bus.CmdAddr;
              state_d = S_ACCESS;
            end else begin
              state_d = S_SAMPLE;
            end
          end
        end
        S_ACCESS: begin
          if (lat_q == LAT_LAST) begin
            lat_d = '0;
            if (rw_q) state_d = S_SAMPLE;
            else      beat_end = 1'b1;
          end else begin
            lat_d = lat_q + 1'b1;
          end
        end
        S_SAMPLE: begin
          state_d  = S_TX;
          tx_cnt_d = '0;
        end
        S_TX: begin
          if (bus.TxDone) begin
            beat_end = 1'b1;
          end else if (tx_cnt_q == TX_LAST) begin
`ifdef RWBS_TX_TIMEOUT_EN
            state_d = S_IDLE;
            err_d   = 1'b1;
`endif
          end else begin
            tx_cnt_d = tx_cnt_q + 1'b1;
          end
        end
      endcase

      if (beat_end) begin
        if (beats_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          beats_d = beats_q - 1'b1;
          if (mode_q) begin
            addr_d  = addr_q + 1'b1;
            state_d = S_ACCESS;
          end else begin
            state_d = S_SAMPLE;
          end
        end
      end
    end

    // Strobes are registered copies of the next state so they change only on Clk.
    access_d = (state_d == S_ACCESS);
    rwmem_d  = (state_d == S_ACCESS) && rw_d;
    sample_d = (state_d == S_SAMPLE);
    tx_d     = (state_d == S_TX);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      beats_q  <= '0;
      lat_q    <= '0;
      tx_cnt_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      access_q <= 1'b0;
      rwmem_q  <= 1'b0;
      sample_q <= 1'b0;
      tx_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      beats_q  <= beats_d;
      lat_q    <= lat_d;
      tx_cnt_q <= tx_cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      access_q <= access_d;
      rwmem_q  <= rwmem_d;
      sample_q <= sample_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_rw_burst_sequencer.sv
module tb_rw_burst_sequencer;

  localparam int ADDR_W     = 8;
  localparam int BURST_W    = 2;
  localparam int MEM_LAT    = 2;
  localparam int TX_TIMEOUT = 8;

  typedef struct packed {
    logic       acc;
    logic       rw;
    logic [7:0] addr;
    logic       smp;
    logic       tx;
    logic       busy;
    logic       done;
    logic       err;
  } obs_t;

  logic  Clk = 1'b0;
  logic  Reset;
  obs_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  string tag;

  always #5 Clk = ~Clk;

  rw_burst_sequencer_if #(.ADDR_W(ADDR_W), .BURST_W(BURST_W)) bus ();

  rw_burst_sequencer #(
    .ADDR_W(ADDR_W), .BURST_W(BURST_W), .MEM_LAT(MEM_LAT), .TX_TIMEOUT(TX_TIMEOUT)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  function automatic obs_t mk(logic acc, logic rw, logic [7:0] addr, logic smp,
                              logic tx, logic busy, logic done, logic err);
    obs_t o;
    o = '{acc: acc, rw: rw, addr: addr, smp: smp, tx: tx, busy: busy, done: done, err: err};
    return o;
  endfunction

  function automatic obs_t observe();
    return mk(bus.AccessMem, bus.RWMem, bus.MemAddr, bus.SampleData,
              bus.TxData, bus.Busy, bus.Done, bus.Error);
  endfunction

  task automatic check_obs(string name);
    obs_t o;
    obs_t e;
    o = observe();
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty, observed=%h required=<none>", name, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        errors++;
        $error("FAIL %s observed acc/rw/addr/smp/tx/busy/done/err=%h required=%h", name, o, e);
      end
    end
  endtask

  task automatic check_bit(string name, logic observed, logic expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%b required=%b", name, observed, expected);
    end
  endtask

  // One edge per iteration; txd[i] is the TxDone level presented before edge i+1.
  task automatic run(int n, logic [31:0] txd, bit hold);
    for (int i = 0; i < n; i++) begin
      bus.TxDone = txd[i];
      @(posedge Clk);
      #1;
      check_obs($sformatf("%s.e%0d", tag, i + 1));
      if (!hold) bus.CmdValid = 1'b0;
    end
    bus.TxDone = 1'b0;
  endtask

  task automatic issue(logic mode, logic rw, logic [7:0] addr, logic [1:0] len);
    bus.CmdMode  = mode;
    bus.CmdRW    = rw;
    bus.CmdAddr  = addr;
    bus.CmdLen   = len;
    bus.CmdValid = 1'b1;
    #1;
    check_bit({tag, ".CmdReady"}, bus.CmdReady, 1'b1);
  endtask

  initial begin
    Reset        = 1'b1;
    bus.Active   = 1'b0;
    bus.CmdValid = 1'b0;
    bus.CmdMode  = 1'b0;
    bus.CmdRW    = 1'b0;
    bus.CmdAddr  = '0;
    bus.CmdLen   = '0;
    bus.TxDone   = 1'b0;

    // Reset state
    tag = "reset";
    #3;
    exp_q.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0));
    check_obs("reset.state");
    check_bit("reset.CmdReady_inactive", bus.CmdReady, 1'b0);
    @(posedge Clk);
    #1;
    Reset      = 1'b0;
    bus.Active = 1'b1;
    exp_q.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0));
    run(1, 32'h0, 1'b0);

    // Write burst, two beats, MEM_LAT cycles each
    tag = "wr_burst";
    issue(1'b1, 1'b0, 8'h10, 2'd1);
    for (int i = 0; i < 4; i++)
      exp_q.push_back(mk(1, 0, (i < 2) ? 8'h10 : 8'h11, 0, 0, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 8'h11, 0, 0, 0, 1, 0));
    exp_q.push_back(mk(0, 0, 8'h11, 0, 0, 0, 0, 0));
    run(6, 32'h0, 1'b0);

    // Read-sample-transmit burst with address wrap; stray TxDone during ACCESS
    tag = "rd_burst";
    issue(1'b1, 1'b1, 8'hFF, 2'd1);
    for (int b = 0; b < 2; b++) begin
      logic [7:0] a;
      a = (b == 0) ? 8'hFF : 8'h00;
      exp_q.push_back(mk(1, 1, a, 0, 0, 1, 0, 0));
      exp_q.push_back(mk(1, 1, a, 0, 0, 1, 0, 0));
      exp_q.push_back(mk(0, 0, a, 1, 0, 1, 0, 0));
      for (int t = 0; t < 3; t++) exp_q.push_back(mk(0, 0, a, 0, 1, 1, 0, 0));
    end
    exp_q.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 0));
    exp_q.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0));
    run(14, 32'h0000_1042, 1'b0);

    // Sample/transmit single beat; MemAddr keeps its previous value
    tag = "smp_tx";
    issue(1'b0, 1'b1, 8'h55, 2'd0);
    exp_q.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0, 0));
    for (int t = 0; t < 5; t++) exp_q.push_back(mk(0, 0, 8'h00, 0, 1, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 8'h00, 0, 0, 0, 1, 0));
    exp_q.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0));
    run(8, 32'h0000_0041, 1'b0);

    // Active dropped in the TX phase of a burst
    tag = "abort";
    issue(1'b1, 1'b1, 8'h20, 2'd2);
    exp_q.push_back(mk(1, 1, 8'h20, 0, 0, 1, 0, 0));
    exp_q.push_back(mk(1, 1, 8'h20, 0, 0, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 8'h20, 1, 0, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 8'h20, 0, 1, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 8'h20, 0, 1, 1, 0, 0));
    run(5, 32'h0, 1'b0);
    bus.Active   = 1'b0;
    bus.CmdValid = 1'b1;
    #1;
    check_bit("abort.CmdReady_inactive", bus.CmdReady, 1'b0);
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0));
    run(3, 32'h0, 1'b1);
    bus.Active   = 1'b1;
    bus.CmdValid = 1'b0;
    exp_q.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0));
    run(1, 32'h0, 1'b0);

    // Asynchronous reset between edges while in ACCESS
    tag = "async_rst";
    issue(1'b1, 1'b0, 8'h30, 2'd0);
    exp_q.push_back(mk(1, 0, 8'h30, 0, 0, 1, 0, 0));
    run(1, 32'h0, 1'b0);
    #2;
    Reset = 1'b1;
    #1;
    exp_q.push_back(mk(0, 0, 8'h00, 0, 0, 0, 0, 0));
    check_obs("async_rst.immediate");
    #2;
    Reset = 1'b0;

    // Back-to-back commands with CmdValid held high
    tag = "b2b";
    issue(1'b1, 1'b0, 8'h40, 2'd0);
    exp_q.push_back(mk(1, 0, 8'h40, 0, 0, 1, 0, 0));
    exp_q.push_back(mk(1, 0, 8'h40, 0, 0, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 8'h40, 0, 0, 0, 1, 0));
    run(3, 32'h0, 1'b1);
    check_bit("b2b.CmdReady_on_done", bus.CmdReady, 1'b1);
    exp_q.push_back(mk(1, 0, 8'h40, 0, 0, 1, 0, 0));
    exp_q.push_back(mk(1, 0, 8'h40, 0, 0, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 8'h40, 0, 0, 0, 1, 0));
    run(3, 32'h0, 1'b1);
    bus.CmdValid = 1'b0;
    exp_q.push_back(mk(0, 0, 8'h40, 0, 0, 0, 0, 0));
    run(1, 32'h0, 1'b0);

`ifdef RWBS_TX_TIMEOUT_EN
    // TX watchdog: abort after TX_TIMEOUT cycles, Error sticky until next accept
    tag = "timeout";
    issue(1'b0, 1'b0, 8'h00, 2'd0);
    exp_q.push_back(mk(0, 0, 8'h40, 1, 0, 1, 0, 0));
    for (int t = 0; t < TX_TIMEOUT; t++) exp_q.push_back(mk(0, 0, 8'h40, 0, 1, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 8'h40, 0, 0, 0, 0, 1));
    exp_q.push_back(mk(0, 0, 8'h40, 0, 0, 0, 0, 1));
    run(TX_TIMEOUT + 3, 32'h0, 1'b0);
    tag = "err_clear";
    issue(1'b0, 1'b0, 8'h00, 2'd0);
    exp_q.push_back(mk(0, 0, 8'h40, 1, 0, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 8'h40, 0, 1, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 8'h40, 0, 0, 0, 1, 0));
    run(3, 32'h0000_0004, 1'b0);
`else
    // Without the watchdog TX waits for TxDone however long it takes
    tag = "long_tx";
    issue(1'b0, 1'b0, 8'h00, 2'd0);
    exp_q.push_back(mk(0, 0, 8'h40, 1, 0, 1, 0, 0));
    for (int t = 0; t < 20; t++) exp_q.push_back(mk(0, 0, 8'h40, 0, 1, 1, 0, 0));
    exp_q.push_back(mk(0, 0, 8'h40, 0, 0, 0, 1, 0));
    exp_q.push_back(mk(0, 0, 8'h40, 0, 0, 0, 0, 0));
    run(23, 32'h0020_0000, 1'b0);
`endif

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d leftover required=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
